// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between fetch (I) and data (D), one transaction at a time.
// Min latency 2 cycles req->done; losers hold their level request until their own done pulse.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_byteen,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byteen,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_I_BUSY = 2'd1;
    localparam logic [1:0] ST_D_BUSY = 2'd2;

    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
    localparam logic [TW-1:0]   TMO_LAST   = TW'(TIMEOUT - 1);

    logic [1:0]      state;
    logic [SC_W-1:0] starve_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      byteen_q;
    logic            we_q;
    logic            grant_d;
    logic            grant_i;
    logic            is_d;

    // D wins unless I has already watched STARVE_MAX consecutive D grants go by.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == ST_IDLE) begin
            if (d_req && (!i_req || (starve_cnt < STARVE_LIM))) begin
                grant_d = 1'b1;
            end else if (i_req) begin
                grant_i = 1'b1;
            end
        end
    end

    assign busy       = (state != ST_IDLE);
    assign is_d       = (state == ST_D_BUSY);
    assign mem_req    = busy;
    assign mem_we     = we_q & busy;
    assign mem_addr   = addr_q;
    assign mem_byteen = byteen_q;
    assign mem_wdata  = wdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            byteen_q   <= '0;
            we_q       <= 1'b0;
            i_done     <= 1'b0;
            i_err      <= 1'b0;
            i_rdata    <= '0;
            d_done     <= 1'b0;
            d_err      <= 1'b0;
            d_rdata    <= '0;
        end else begin
            i_done <= 1'b0;
            i_err  <= 1'b0;
            d_done <= 1'b0;
            d_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_d) begin
                        state      <= ST_D_BUSY;
                        addr_q     <= d_addr;
                        we_q       <= d_we;
                        byteen_q   <= d_we ? d_byteen : 4'b0000;
                        wdata_q    <= d_wdata;
                        tmo_cnt    <= '0;
                        starve_cnt <= i_req ? starve_cnt + SC_W'(1) : '0;
                    end else if (grant_i) begin
                        state      <= ST_I_BUSY;
                        addr_q     <= i_addr;
                        we_q       <= 1'b0;
                        byteen_q   <= 4'b0000;
                        wdata_q    <= '0;
                        tmo_cnt    <= '0;
                        starve_cnt <= '0;
                    end
                end
                ST_I_BUSY, ST_D_BUSY: begin
                    if (mem_ready) begin
                        if (is_d) begin
                            d_done <= 1'b1;
                            if (!we_q) begin
                                d_rdata <= mem_rdata;
                            end
                        end else begin
                            i_done  <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                        state <= ST_IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Abort: report the error but keep the previous rdata.
                        if (is_d) begin
                            d_done <= 1'b1;
                            d_err  <= 1'b1;
                        end else begin
                            i_done <= 1'b1;
                            i_err  <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random rounds against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req, i_done, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_done, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_byteen;
    logic        mem_req, mem_we, mem_ready, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_byteen;

    int n_checks = 0;
    int n_err    = 0;

    bit          i_pend = 0;
    bit          d_pend = 0;
    int          starve = 0;
    logic [31:0] exp_i = '0;
    logic [31:0] exp_d = '0;
    int          wait_cyc = 0;
    bit          hang = 0;
    int          rsp_cnt = 0;
    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_byteen(d_byteen), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_byteen(mem_byteen),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0000_1357;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h1000 + 32'($urandom_range(0, 15)) * 32'd4;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Memory: answers wait_cyc cycles into each request, or never while hang is set.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req && !hang) begin
                if (rsp_cnt == wait_cyc) begin
                    mem_ready = 1'b1;
                    mem_rdata = env_rd(mem_addr);
                    if (mem_we) env_mem[mem_addr] = merge(env_rd(mem_addr), mem_wdata, mem_byteen);
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                end
                rsp_cnt++;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                rsp_cnt   = 0;
            end
        end
    end

    // One arbitration round from an IDLE negedge through the winner's done pulse.
    task automatic round(input int wt, input bit hang_i, input bit scramble, output bit obs_d);
        bit          won_d, we, got;
        logic [31:0] a, wd;
        logic [3:0]  be;
        int          cyc, bcyc, exp_lat;
        if (d_pend && (!i_pend || starve < STARVE_MAX)) begin
            won_d  = 1;
            starve = i_pend ? starve + 1 : 0;
        end else begin
            won_d  = 0;
            starve = 0;
        end
        a  = won_d ? d_addr : i_addr;
        we = won_d && d_we;
        be = we ? d_byteen : 4'b0000;
        wd = d_wdata;
        i_req    = i_pend;
        d_req    = d_pend;
        wait_cyc = wt;
        hang     = hang_i;
        exp_lat  = hang_i ? TIMEOUT + 1 : wt + 2;
        cyc = 0; bcyc = 0; got = 0;
        while (!got && cyc < exp_lat + 8) begin
            @(negedge clk);
            cyc++;
            if (i_done || d_done) begin
                got = 1;
            end else if (busy) begin
                bcyc++;
                check("mem_req", 32'(mem_req), 32'd1);
                check("mem_addr", mem_addr, a);
                check("mem_we", 32'(mem_we), 32'(we));
                check("mem_byteen", 32'(mem_byteen), 32'(be));
                if (we) check("mem_wdata", mem_wdata, wd);
                if (scramble) begin
                    if (won_d) begin
                        d_addr = $urandom; d_wdata = $urandom; d_byteen = 4'($urandom); d_we = ~d_we;
                    end else begin
                        i_addr = $urandom;
                    end
                end
            end
        end
        obs_d = d_done;
        check("latency", 32'(cyc), 32'(exp_lat));
        check("busy_cycles", 32'(bcyc), 32'(exp_lat - 1));
        check("done_owner", 32'({i_done, d_done}), won_d ? 32'd1 : 32'd2);
        check("err", 32'({i_err, d_err}), hang_i ? (won_d ? 32'd1 : 32'd2) : 32'd0);
        check("idle_at_done", 32'({busy, mem_req}), 32'd0);
        if (!hang_i) begin
            if (!won_d) exp_i = ref_rd(a);
            else if (!we) exp_d = ref_rd(a);
            else ref_mem[a] = merge(ref_rd(a), wd, be);
        end
        check("i_rdata", i_rdata, exp_i);
        check("d_rdata", d_rdata, exp_d);
        hang = 0;
        if (won_d) begin d_pend = 0; d_req = 0; end
        else begin i_pend = 0; i_req = 0; end
    endtask

    initial begin
        bit w;
        int stale;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_byteen = 0; d_wdata = 0;
        repeat (2) @(negedge clk);
        check("rst_done", 32'({i_done, d_done, i_err, d_err}), 32'd0);
        check("rst_mem_req", 32'({mem_req, mem_we, busy}), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_byteen", 32'(mem_byteen), 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        reset = 1;
        @(negedge clk);
        check("idle_no_req", 32'(busy), 32'd0);

        env_mem[32'h100] = 32'hDEAD_BEEF;
        ref_mem[32'h100] = 32'hDEAD_BEEF;
        d_we = 0; d_addr = 32'h100; d_byteen = 4'hF; d_pend = 1;
        round(0, 0, 0, w);
        check("load_d_rdata", d_rdata, 32'hDEAD_BEEF);

        d_we = 1; d_addr = 32'h204; d_byteen = 4'b0011; d_wdata = 32'h1234_5678; d_pend = 1;
        round(0, 0, 0, w);
        check("store_keeps_rdata", d_rdata, 32'hDEAD_BEEF);
        d_we = 0; d_addr = 32'h204; d_pend = 1;
        round(1, 0, 0, w);

        d_we = 1; d_addr = 32'h300; d_byteen = 4'b1100; d_wdata = 32'hA5A5_5A5A; d_pend = 1;
        round(2, 0, 1, w);
        d_we = 0; d_addr = 32'h300; d_pend = 1;
        round(0, 0, 0, w);

        i_addr = 32'h44; i_pend = 1;
        round(0, 0, 0, w);
        i_addr = 32'h40; i_pend = 1;
        round(0, 1, 0, w);
        check("tmo_i_rdata_kept", i_rdata, dflt(32'h44));
        d_we = 0; d_addr = 32'h100; d_pend = 1;
        round(0, 0, 0, w);

        for (int k = 0; k < 13; k++) begin
            if (!i_pend) begin i_pend = 1; i_addr = rand_addr(); end
            if (!d_pend) begin d_pend = 1; d_we = 0; d_addr = rand_addr(); end
            round($urandom_range(0, 2), 0, 0, w);
            check("starve_order", 32'(w), 32'((k % 5) != 4));
        end

        // Contested D grant (fourth in a row), then reset while it hangs.
        d_we = 0; d_addr = 32'h500; d_pend = 1; i_req = 1; d_req = 1; hang = 1;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_owner", mem_addr, 32'h500);
        #2 reset = 0;
        #1;
        check("async_rst_req", 32'({mem_req, busy}), 32'd0);
        check("async_rst_done", 32'({i_done, d_done}), 32'd0);
        check("async_rst_rdata", d_rdata | i_rdata, 32'd0);
        i_req = 0; d_req = 0;
        @(negedge clk);
        reset = 1; hang = 0;
        i_pend = 0; d_pend = 0; starve = 0; exp_i = '0; exp_d = '0;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (d_done || i_done || busy) stale++;
        end
        check("no_stale_done", 32'(stale), 32'd0);
        i_pend = 1; i_addr = rand_addr(); d_pend = 1; d_we = 0; d_addr = rand_addr();
        round(0, 0, 0, w);
        check("post_rst_grant_d", 32'(w), 32'd1);

        for (int r = 0; r < 40; r++) begin
            if (!i_pend && $urandom_range(0, 1) == 1) begin i_pend = 1; i_addr = rand_addr(); end
            if (!d_pend && ($urandom_range(0, 1) == 1 || !i_pend)) begin
                d_pend = 1; d_we = 1'($urandom_range(0, 1)); d_addr = rand_addr();
                d_byteen = 4'($urandom); d_wdata = $urandom;
            end
            round($urandom_range(0, 3), $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), w);
        end
        @(negedge clk);
        check("single_done_pulse", 32'({i_done, d_done}), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
